// File: rtl/input_debouncer.sv
// Per-channel synchroniser plus debounce FSM producing clean levels and rise/fall strobes.
// Optional rejected-bounce statistics counter enabled by INPUT_DEBOUNCE_STATS_EN.
module input_debouncer #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] in_clean,
    output logic [WIDTH-1:0] in_rise,
    output logic [WIDTH-1:0] in_fall
`ifdef INPUT_DEBOUNCE_STATS_EN
    ,
    output logic [15:0]      glitch_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_SETTLING = 1'b1;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_nxt;
    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] w_clean_nxt;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // Synchroniser chain: the only consumer of the asynchronous pins.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in_raw;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCE_STATS_EN
    localparam int unsigned REJ_W = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] w_rej;
    logic [REJ_W-1:0] w_rej_sum;
    logic [16:0]      w_glitch_sum;
    logic [15:0]      r_glitch;
`endif

    // Next-state logic for every channel's STABLE/SETTLING FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_clean_nxt = r_clean;
`ifdef INPUT_DEBOUNCE_STATS_EN
        w_rej       = '0;
`endif
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    w_cnt_nxt[i] = '0;
                    if (w_sync[i] != r_clean[i]) begin
                        w_state_nxt[i] = ST_SETTLING;
                        w_cnt_nxt[i]   = CNT_W'(1);
                    end
                end
                ST_SETTLING: begin
                    if (w_sync[i] != r_clean[i]) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_clean_nxt[i] = w_sync[i];
                            w_cnt_nxt[i]   = '0;
                            w_state_nxt[i] = ST_STABLE;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                        end
                    end else begin
                        // Input fell back before the window completed: bounce rejected.
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_STABLE;
`ifdef INPUT_DEBOUNCE_STATS_EN
                        w_rej[i]       = 1'b1;
`endif
                    end
                end
                default: begin
                    w_cnt_nxt[i]   = '0;
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
        end
    end

    // FSM state, counters, clean level and strobes.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {WIDTH{ST_STABLE}};
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_clean_nxt & ~r_clean;
            r_fall  <= ~w_clean_nxt & r_clean;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign in_clean = r_clean;
    assign in_rise  = r_rise;
    assign in_fall  = r_fall;

`ifdef INPUT_DEBOUNCE_STATS_EN
    // Rejections from all channels in one cycle are summed, then saturated.
    always_comb begin
        w_rej_sum = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_rej_sum = w_rej_sum + REJ_W'(w_rej[i]);
        end
        w_glitch_sum = {1'b0, r_glitch} + 17'(w_rej_sum);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch <= '0;
        end else if (w_glitch_sum[16]) begin
            r_glitch <= 16'hFFFF;
        end else begin
            r_glitch <= w_glitch_sum[15:0];
        end
    end

    assign glitch_count = r_glitch;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random bouncing inputs against a run-length model.
module tb_input_debouncer;

    localparam int unsigned W   = 5;
    localparam int unsigned SS  = 2;
    localparam int unsigned DEB = 4;

    logic         clk_100mhz = 1'b0;
    logic         rst_n      = 1'b0;
    logic [W-1:0] in_raw     = '0;
    logic [W-1:0] in_clean;
    logic [W-1:0] in_rise;
    logic [W-1:0] in_fall;
`ifdef INPUT_DEBOUNCE_STATS_EN
    logic [15:0]  glitch_count;
`endif

    input_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .rst_n     (rst_n),
        .in_raw    (in_raw),
        .in_clean  (in_clean),
        .in_rise   (in_rise),
        .in_fall   (in_fall)
`ifdef INPUT_DEBOUNCE_STATS_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int errors = 0;

    // Reference model: raw history, accepted level, and length of the current disagreement run.
    logic [W-1:0] m_hist [SS];
    logic [W-1:0] m_clean;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_run [W];
    int           m_glitch;

    task automatic model_reset();
        for (int k = 0; k < int'(SS); k++) m_hist[k] = '0;
        m_clean = '0; m_rise = '0; m_fall = '0; m_glitch = 0;
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] s;
        int rej;
        s = m_hist[SS-1];
        rej = 0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (s[i] != m_clean[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(DEB)) begin
                    m_clean[i] = s[i];
                    m_run[i] = 0;
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end else if (m_run[i] > 0) begin
                rej++;
                m_run[i] = 0;
            end
        end
        m_glitch = (m_glitch + rej > 65535) ? 65535 : m_glitch + rej;
        for (int k = int'(SS) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = in_raw;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("clean_vs_model", 32'(in_clean), 32'(m_clean));
        check("rise_vs_model",  32'(in_rise),  32'(m_rise));
        check("fall_vs_model",  32'(in_fall),  32'(m_fall));
`ifdef INPUT_DEBOUNCE_STATS_EN
        check("glitch_vs_model", 32'(glitch_count), 32'(m_glitch));
`endif
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        if (rst_n) model_step();
        #1;
        check_model();
    endtask

    task automatic set_raw(input logic [W-1:0] v);
        @(negedge clk_100mhz);
        in_raw = v;
    endtask

    logic [W-1:0] v;
    logic         seen;

    initial begin
        model_reset();
        in_raw = 5'h1F;
        // Reset held with all inputs high.
        for (int n = 0; n < 4; n++) begin
            tick();
            check("reset_clean", 32'(in_clean), 32'h0);
            check("reset_strobes", 32'({in_rise, in_fall}), 32'h0);
        end
        set_raw('0);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) tick();

        // Clean rise on channel 0.
        set_raw(5'b00001);
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n < 6) check("rise0_early", 32'(in_clean[0]), 32'h0);
            if (n == 6) begin
                check("rise0_clean", 32'(in_clean[0]), 32'h1);
                check("rise0_strobe", 32'(in_rise[0]), 32'h1);
            end
            if (n == 7) check("rise0_single", 32'(in_rise[0]), 32'h0);
        end

        // Bounce on channel 1: high for three cycles then low.
        set_raw(5'b00011);
        seen = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        set_raw(5'b00001);
        for (int n = 0; n < 10; n++) begin
            tick();
            seen = seen | in_clean[1] | in_rise[1] | in_fall[1];
        end
        check("bounce_no_change", 32'(seen), 32'h0);
`ifdef INPUT_DEBOUNCE_STATS_EN
        check("bounce_glitch_count", 32'(glitch_count), 32'h1);
`endif

        // Return to zero, then multi-channel rise.
        set_raw('0);
        for (int n = 0; n < 10; n++) tick();
        check("all_low", 32'(in_clean), 32'h0);
        set_raw(5'b10101);
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n < 6) check("multi_early", 32'(in_clean), 32'h0);
            if (n == 6) begin
                check("multi_clean", 32'(in_clean), 32'h15);
                check("multi_rise", 32'(in_rise), 32'h15);
            end
            if (n == 7) check("multi_single", 32'(in_rise), 32'h0);
        end

        // Async reset while channel 2 is part-way through settling.
        set_raw('0);
        for (int n = 0; n < 10; n++) tick();
        set_raw(5'b00100);
        for (int n = 0; n < 5; n++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_clean", 32'(in_clean), 32'h0);
        tick();
        tick();
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n < 6) check("postreset_early", 32'(in_clean[2]), 32'h0);
            else begin
                check("postreset_clean", 32'(in_clean[2]), 32'h1);
                check("postreset_rise", 32'(in_rise[2]), 32'h1);
            end
        end

        // Random bouncy inputs: each channel flips with low probability per cycle.
        for (int n = 0; n < 600; n++) begin
            v = in_raw;
            for (int i = 0; i < int'(W); i++) begin
                if ($urandom_range(5, 0) == 0) v[i] = ~v[i];
            end
            set_raw(v);
            tick();
        end

`ifdef INPUT_DEBOUNCE_STATS_EN
        // Saturation: every channel rejects a glitch every second cycle.
        set_raw('0);
        for (int n = 0; n < 10; n++) tick();
        for (int n = 0; n < 28400; n++) begin
            set_raw((n % 2 == 0) ? 5'h1F : 5'h00);
            tick();
        end
        check("glitch_saturated", 32'(glitch_count), 32'hFFFF);
        for (int n = 0; n < 6; n++) begin
            set_raw((n % 2 == 0) ? 5'h1F : 5'h00);
            tick();
        end
        check("glitch_holds", 32'(glitch_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
